// File: rtl/ctrl_pkg.sv
// Shared opcode encodings, ALU operation codes and the control bundle
// carried down the EX/MEM/WB stage registers.
package ctrl_pkg;

   localparam int unsigned REG_W_P = 5;

   // Full 11-bit opcodes (instr[31:21])
   localparam logic [10:0] OP_ADDS = 11'h558;
   localparam logic [10:0] OP_SUBS = 11'h758;
   localparam logic [10:0] OP_ADDI = 11'h488;   // bit 0 is don't-care
   localparam logic [10:0] OP_SUBI = 11'h688;   // bit 0 is don't-care
   localparam logic [10:0] OP_LDUR = 11'h7C2;
   localparam logic [10:0] OP_STUR = 11'h7C0;
   localparam logic [10:0] OP_BR   = 11'h6B0;

   // Prefix opcodes (immediate fields fill the remaining bits)
   localparam logic [5:0]  OP_B     = 6'b000101;
   localparam logic [5:0]  OP_BL    = 6'b100101;
   localparam logic [7:0]  OP_CBZ   = 8'b10110100;
   localparam logic [7:0]  OP_BCOND = 8'b01010100;

   typedef enum logic [2:0] {
      ALU_PASSB = 3'b000,
      ALU_ADD   = 3'b010,
      ALU_SUB   = 3'b011
   } aluop_e;

   typedef struct packed {
      logic                 reg2loc;
      logic                 uncond_br;
      logic                 br;
      logic                 cbz;
      logic                 bcond;
      logic                 alusrc;
      logic                 alusrc1;
      logic                 en_flags;
      aluop_e               alu_op;
      logic                 mem_wri;
      logic                 mem_read;
      logic                 reg_wri;
      logic                 memtoreg;
      logic                 write_rd;
      logic [REG_W_P-1:0]   rd;
   } ctrl_bundle_t;

   // No side effects; rd parked on the zero register.
   localparam ctrl_bundle_t BUBBLE = '{
      reg2loc:   1'b0,
      uncond_br: 1'b0,
      br:        1'b0,
      cbz:       1'b0,
      bcond:     1'b0,
      alusrc:    1'b0,
      alusrc1:   1'b0,
      en_flags:  1'b0,
      alu_op:    ALU_PASSB,
      mem_wri:   1'b0,
      mem_read:  1'b0,
      reg_wri:   1'b0,
      memtoreg:  1'b0,
      write_rd:  1'b0,
      rd:        '1
   };

endpackage

// File: rtl/ctrl_decode.sv
// Combinational LEGv8 opcode decoder: opcode + rd field -> control bundle.
// Unknown opcodes yield a bubble and raise illegal (not qualified by valid).
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int unsigned LR_IDX = 30
) (
   input  logic [10:0]        opcode,
   input  logic [REG_W_P-1:0] rd_field,
   output ctrl_bundle_t       ctrl,
   output logic               illegal
);

   // Opcode match; every field not explicitly set stays 0
   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      if (opcode == OP_ADDS || opcode == OP_SUBS) begin
         ctrl.reg2loc  = 1'b1;
         ctrl.en_flags = 1'b1;
         ctrl.reg_wri  = 1'b1;
         ctrl.write_rd = 1'b1;
         ctrl.rd       = rd_field;
         ctrl.alu_op   = (opcode == OP_SUBS) ? ALU_SUB : ALU_ADD;
      end else if (opcode[10:1] == OP_ADDI[10:1] || opcode[10:1] == OP_SUBI[10:1]) begin
         ctrl.alusrc   = 1'b1;
         ctrl.alusrc1  = (opcode[10:1] == OP_ADDI[10:1]);
         ctrl.reg_wri  = 1'b1;
         ctrl.write_rd = 1'b1;
         ctrl.rd       = rd_field;
         ctrl.alu_op   = (opcode[10:1] == OP_ADDI[10:1]) ? ALU_ADD : ALU_SUB;
      end else if (opcode == OP_LDUR) begin
         ctrl.memtoreg = 1'b1;
         ctrl.mem_read = 1'b1;
         ctrl.reg_wri  = 1'b1;
         ctrl.write_rd = 1'b1;
         ctrl.rd       = rd_field;
         ctrl.alu_op   = ALU_ADD;
      end else if (opcode == OP_STUR) begin
         ctrl.mem_wri  = 1'b1;
         ctrl.alu_op   = ALU_ADD;
      end else if (opcode[10:5] == OP_B) begin
         ctrl.uncond_br = 1'b1;
      end else if (opcode[10:5] == OP_BL) begin
         ctrl.uncond_br = 1'b1;
         ctrl.reg_wri   = 1'b1;
         ctrl.rd        = REG_W_P'(LR_IDX);
      end else if (opcode[10:3] == OP_CBZ) begin
         ctrl.cbz    = 1'b1;
         ctrl.alu_op = ALU_PASSB;
      end else if (opcode[10:3] == OP_BCOND) begin
         ctrl.bcond = 1'b1;
      end else if (opcode == OP_BR) begin
         ctrl.br = 1'b1;
      end else begin
         ctrl    = BUBBLE;
         illegal = 1'b1;
      end
   end

endmodule

// File: rtl/ctrl_pipeline_unit.sv
// Pipelined LEGv8 control unit: decodes IF/ID, carries the control bundle
// through EX/MEM/WB, detects load-use and flag-use hazards and counts
// stall/flush events with saturating counters.
module ctrl_pipeline_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned REG_W     = 5,
   parameter int unsigned ALUOP_W   = 3,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned LR_IDX    = 30,
   parameter int unsigned HAZARD_EN = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_valid,
   input  logic [31:0]        id_instr,
   input  logic               flush_i,
   output logic               stall_o,
   output logic               illegal,
   output logic               id_reg2loc,
   output logic               id_uncond_br,
   output logic               id_br,
   output logic               id_cbz,
   output logic               id_bcond,
   output logic               ex_alusrc,
   output logic               ex_alusrc1,
   output logic               ex_en_flags,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               mem_wri,
   output logic               mem_read,
   output logic               wb_reg_wri,
   output logic               wb_memtoreg,
   output logic               wb_write_rd,
   output logic [REG_W-1:0]   ex_rd,
   output logic [REG_W-1:0]   mem_rd,
   output logic [REG_W-1:0]   wb_rd,
   output logic [CNT_W-1:0]   stall_count,
   output logic [CNT_W-1:0]   flush_count
);

   localparam logic HAZ_ON = (HAZARD_EN != 0);

   ctrl_bundle_t       dec;
   ctrl_bundle_t       ex_q;
   ctrl_bundle_t       mem_q;
   ctrl_bundle_t       wb_q;
   logic               dec_illegal;
   logic [REG_W_P-1:0] src_rn;
   logic [REG_W_P-1:0] src_rm;
   logic               use_rn;
   logic               use_rm;
   logic               load_use;
   logic               flag_use;
   logic               stall;
   logic               unused_bits;

   ctrl_decode #(
      .LR_IDX (LR_IDX)
   ) u_decode (
      .opcode   (id_instr[31:21]),
      .rd_field (id_instr[4:0]),
      .ctrl     (dec),
      .illegal  (dec_illegal)
   );

   // Immediate/shamt bits and late-stage fields that no output consumes
   assign unused_bits = ^{id_instr[15:10], wb_q};

   // Hazard detection against the instruction currently in EX
   always_comb begin
      src_rn   = id_instr[9:5];
      src_rm   = dec.reg2loc ? id_instr[20:16] : id_instr[4:0];
      use_rn   = ~dec_illegal & ~dec.uncond_br & ~dec.bcond;
      use_rm   = ~dec_illegal & ~dec.alusrc;
      load_use = ex_q.mem_read & (ex_q.rd != '1) &
                 ((use_rn & (ex_q.rd == src_rn)) | (use_rm & (ex_q.rd == src_rm)));
      flag_use = dec.bcond & ex_q.en_flags;
      stall    = HAZ_ON & id_valid & (load_use | flag_use) & ~flush_i;
   end

   // Stage registers: MEM/WB always advance, EX takes a bubble on flush/stall/no-op
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= BUBBLE;
         mem_q <= BUBBLE;
         wb_q  <= BUBBLE;
      end else begin
         mem_q <= ex_q;
         wb_q  <= mem_q;
         if (flush_i || stall || !id_valid || dec_illegal)
            ex_q <= BUBBLE;
         else
            ex_q <= dec;
      end
   end

   // Saturating stall/flush event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (flush_i && flush_count != '1)
            flush_count <= flush_count + CNT_W'(1);
         if (stall && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
      end
   end

   assign stall_o      = stall;
   assign illegal      = id_valid & dec_illegal;
   assign id_reg2loc   = dec.reg2loc;
   assign id_uncond_br = dec.uncond_br;
   assign id_br        = dec.br;
   assign id_cbz       = dec.cbz;
   assign id_bcond     = dec.bcond;
   assign ex_alusrc    = ex_q.alusrc;
   assign ex_alusrc1   = ex_q.alusrc1;
   assign ex_en_flags  = ex_q.en_flags;
   assign ex_alu_op    = ALUOP_W'(ex_q.alu_op);
   assign ex_rd        = REG_W'(ex_q.rd);
   assign mem_wri      = mem_q.mem_wri;
   assign mem_read     = mem_q.mem_read;
   assign mem_rd       = REG_W'(mem_q.rd);
   assign wb_reg_wri   = wb_q.reg_wri;
   assign wb_memtoreg  = wb_q.memtoreg;
   assign wb_write_rd  = wb_q.write_rd;
   assign wb_rd        = REG_W'(wb_q.rd);

endmodule

// File: tb/tb_ctrl_pipeline_unit.sv
// Testbench for ctrl_pipeline_unit: scoreboard of expected EX/MEM/WB
// controls plus per-scenario hazard, counter and decode checks.
module tb_ctrl_pipeline_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_instr;
   logic        flush_i;

   logic        stall_o, illegal;
   logic        id_reg2loc, id_uncond_br, id_br, id_cbz, id_bcond;
   logic        ex_alusrc, ex_alusrc1, ex_en_flags;
   logic [2:0]  ex_alu_op;
   logic        mem_wri, mem_read, wb_reg_wri, wb_memtoreg, wb_write_rd;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic [15:0] stall_count, flush_count;

   // Narrow-counter instance sharing the same stimulus
   logic        unused_s_stall, unused_s_illegal;
   logic        unused_s_r2l, unused_s_ub, unused_s_br, unused_s_cbz, unused_s_bc;
   logic        unused_s_as, unused_s_as1, unused_s_ef;
   logic [2:0]  unused_s_aop;
   logic        unused_s_mw, unused_s_mr, unused_s_rw, unused_s_m2r, unused_s_wrd;
   logic [4:0]  unused_s_exrd, unused_s_memrd, unused_s_wbrd;
   logic [1:0]  s_stall_count, s_flush_count;

   always #5 clk = ~clk;

   ctrl_pipeline_unit dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .flush_i(flush_i),
      .stall_o(stall_o), .illegal(illegal),
      .id_reg2loc(id_reg2loc), .id_uncond_br(id_uncond_br), .id_br(id_br),
      .id_cbz(id_cbz), .id_bcond(id_bcond),
      .ex_alusrc(ex_alusrc), .ex_alusrc1(ex_alusrc1), .ex_en_flags(ex_en_flags),
      .ex_alu_op(ex_alu_op), .mem_wri(mem_wri), .mem_read(mem_read),
      .wb_reg_wri(wb_reg_wri), .wb_memtoreg(wb_memtoreg), .wb_write_rd(wb_write_rd),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   ctrl_pipeline_unit #(.CNT_W(2)) sat_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .flush_i(flush_i),
      .stall_o(unused_s_stall), .illegal(unused_s_illegal),
      .id_reg2loc(unused_s_r2l), .id_uncond_br(unused_s_ub), .id_br(unused_s_br),
      .id_cbz(unused_s_cbz), .id_bcond(unused_s_bc),
      .ex_alusrc(unused_s_as), .ex_alusrc1(unused_s_as1), .ex_en_flags(unused_s_ef),
      .ex_alu_op(unused_s_aop), .mem_wri(unused_s_mw), .mem_read(unused_s_mr),
      .wb_reg_wri(unused_s_rw), .wb_memtoreg(unused_s_m2r), .wb_write_rd(unused_s_wrd),
      .ex_rd(unused_s_exrd), .mem_rd(unused_s_memrd), .wb_rd(unused_s_wbrd),
      .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   typedef struct packed {
      logic       alusrc;
      logic       alusrc1;
      logic       en_flags;
      logic [2:0] alu_op;
      logic       mem_wri;
      logic       mem_read;
      logic       reg_wri;
      logic       memtoreg;
      logic       write_rd;
      logic [4:0] rd;
   } exp_t;

   localparam exp_t BUB = exp_t'(16'h001F);

   exp_t q_ex[$];
   exp_t q_mem[$];
   exp_t q_wb[$];
   int   total = 0;
   int   bad = 0;
   int   exp_stalls = 0;
   int   exp_flushes = 0;

   // Instruction builders
   function automatic logic [31:0] rfmt(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
      return {op, rm, 6'b000000, rn, rd};
   endfunction

   function automatic logic [31:0] dfmt(input logic [10:0] op, input logic [4:0] rn,
                                        input logic [4:0] rt);
      return {op, 9'd0, 2'b00, rn, rt};
   endfunction

   // Reference decode of the stage-visible controls
   function automatic exp_t ref_dec(input logic [31:0] ins, output logic legal);
      exp_t e;
      e     = '0;
      legal = 1'b1;
      casez (ins[31:21])
         11'b10101011000: begin e.en_flags = 1; e.alu_op = 3'b010; e.reg_wri = 1; e.write_rd = 1; e.rd = ins[4:0]; end
         11'b11101011000: begin e.en_flags = 1; e.alu_op = 3'b011; e.reg_wri = 1; e.write_rd = 1; e.rd = ins[4:0]; end
         11'b1001000100?: begin e.alusrc = 1; e.alusrc1 = 1; e.alu_op = 3'b010; e.reg_wri = 1; e.write_rd = 1; e.rd = ins[4:0]; end
         11'b1101000100?: begin e.alusrc = 1; e.alu_op = 3'b011; e.reg_wri = 1; e.write_rd = 1; e.rd = ins[4:0]; end
         11'b11111000010: begin e.memtoreg = 1; e.mem_read = 1; e.alu_op = 3'b010; e.reg_wri = 1; e.write_rd = 1; e.rd = ins[4:0]; end
         11'b11111000000: begin e.mem_wri = 1; e.alu_op = 3'b010; end
         11'b000101?????: ;
         11'b100101?????: begin e.reg_wri = 1; e.rd = 5'd30; end
         11'b10110100???: ;
         11'b01010100???: ;
         11'b11010110000: ;
         default:         begin e = BUB; legal = 1'b0; end
      endcase
      return e;
   endfunction

   // Pop expected stage contents and compare after a clock edge
   task automatic scoreboard();
      exp_t e, m, w;
      e = q_ex.pop_front();
      m = q_mem.pop_front();
      w = q_wb.pop_front();
      total++;
      if ({ex_alusrc, ex_alusrc1, ex_en_flags, ex_alu_op, ex_rd} !==
          {e.alusrc, e.alusrc1, e.en_flags, e.alu_op, e.rd}) begin
         bad++;
         $display("FAIL ex_stage got=%h want=%h", {ex_alusrc, ex_alusrc1, ex_en_flags, ex_alu_op, ex_rd},
                  {e.alusrc, e.alusrc1, e.en_flags, e.alu_op, e.rd});
      end
      total++;
      if ({mem_wri, mem_read, mem_rd} !== {m.mem_wri, m.mem_read, m.rd}) begin
         bad++;
         $display("FAIL mem_stage got=%h want=%h", {mem_wri, mem_read, mem_rd}, {m.mem_wri, m.mem_read, m.rd});
      end
      total++;
      if ({wb_reg_wri, wb_memtoreg, wb_write_rd, wb_rd} !== {w.reg_wri, w.memtoreg, w.write_rd, w.rd}) begin
         bad++;
         $display("FAIL wb_stage got=%h want=%h", {wb_reg_wri, wb_memtoreg, wb_write_rd, wb_rd},
                  {w.reg_wri, w.memtoreg, w.write_rd, w.rd});
      end
      q_mem.push_back(e);
      q_wb.push_back(m);
   endtask

   // Present one ID-stage instruction for one cycle
   task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic want_stall);
      exp_t e;
      logic legal;
      id_valid = v;
      id_instr = ins;
      flush_i  = fl;
      #1;
      e = ref_dec(ins, legal);
      total++;
      if (stall_o !== want_stall) begin
         bad++;
         $display("FAIL stall_o instr=%h got=%b want=%b", ins, stall_o, want_stall);
      end
      total++;
      if (illegal !== (v & ~legal)) begin
         bad++;
         $display("FAIL illegal instr=%h got=%b want=%b", ins, illegal, v & ~legal);
      end
      if (want_stall || fl || !v || !legal) e = BUB;
      if (want_stall) exp_stalls++;
      if (fl) exp_flushes++;
      q_ex.push_back(e);
      @(posedge clk);
      #1;
      scoreboard();
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic apply_reset(input int cycles);
      reset    = 1'b1;
      id_valid = 1'b0;
      id_instr = '0;
      flush_i  = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      reset = 1'b0;
      q_ex.delete();
      q_mem.delete();
      q_wb.delete();
      q_mem.push_back(BUB);
      q_wb.push_back(BUB);
      exp_stalls  = 0;
      exp_flushes = 0;
   endtask

   task automatic test_reset();
      apply_reset(2);
      total++;
      if ({ex_alusrc, ex_alusrc1, ex_en_flags, ex_alu_op, mem_wri, mem_read,
           wb_reg_wri, wb_memtoreg, wb_write_rd} !== 9'h000) begin
         bad++;
         $display("FAIL reset_ctrl got=%h want=000", {ex_alusrc, ex_alusrc1, ex_en_flags, ex_alu_op,
                  mem_wri, mem_read, wb_reg_wri, wb_memtoreg, wb_write_rd});
      end
      total++;
      if ({ex_rd, mem_rd, wb_rd} !== {5'd31, 5'd31, 5'd31}) begin
         bad++;
         $display("FAIL reset_rd got=%0d/%0d/%0d want=31/31/31", ex_rd, mem_rd, wb_rd);
      end
      total++;
      if ({stall_count, flush_count} !== 32'h0) begin
         bad++;
         $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_count, flush_count);
      end
   endtask

   task automatic test_adds();
      step(1'b1, rfmt(11'h558, 5'd3, 5'd2, 5'd1), 1'b0, 1'b0);
      total++;
      if ({ex_alu_op, ex_en_flags, ex_rd, id_reg2loc} !== {3'b010, 1'b1, 5'd1, 1'b1}) begin
         bad++;
         $display("FAIL adds_ex got aluop=%b flags=%b rd=%0d r2l=%b want 010/1/1/1",
                  ex_alu_op, ex_en_flags, ex_rd, id_reg2loc);
      end
      idle();
      idle();
      total++;
      if ({wb_reg_wri, wb_rd} !== {1'b1, 5'd1}) begin
         bad++;
         $display("FAIL adds_wb got regwri=%b rd=%0d want 1/1", wb_reg_wri, wb_rd);
      end
   endtask

   task automatic test_mid_stall_reset();
      step(1'b1, dfmt(11'h7C2, 5'd2, 5'd5), 1'b0, 1'b0);
      id_valid = 1'b1;
      id_instr = rfmt(11'h558, 5'd7, 5'd5, 5'd6);
      flush_i  = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({ex_rd, mem_rd, stall_count} !== {5'd31, 5'd31, 16'd0}) begin
         bad++;
         $display("FAIL mid_stall_reset got ex_rd=%0d mem_rd=%0d stalls=%0d want 31/31/0", ex_rd, mem_rd, stall_count);
      end
      reset = 1'b0;
      q_ex.delete();
      q_mem.delete();
      q_wb.delete();
      q_mem.push_back(BUB);
      q_wb.push_back(BUB);
      exp_stalls  = 0;
      exp_flushes = 0;
      step(1'b1, rfmt(11'h558, 5'd7, 5'd5, 5'd6), 1'b0, 1'b0);
      idle();
   endtask

   task automatic test_load_use();
      step(1'b1, dfmt(11'h7C2, 5'd2, 5'd5), 1'b0, 1'b0);
      step(1'b1, rfmt(11'h558, 5'd7, 5'd5, 5'd6), 1'b0, 1'b1);
      total++;
      if (stall_count !== 16'(exp_stalls)) begin
         bad++;
         $display("FAIL load_use_count got=%0d want=%0d", stall_count, exp_stalls);
      end
      step(1'b1, rfmt(11'h558, 5'd7, 5'd5, 5'd6), 1'b0, 1'b0);
      total++;
      if (ex_rd !== 5'd6) begin
         bad++;
         $display("FAIL load_use_resume got ex_rd=%0d want=6", ex_rd);
      end
      idle();
   endtask

   task automatic test_x31_no_stall();
      step(1'b1, dfmt(11'h7C2, 5'd2, 5'd31), 1'b0, 1'b0);
      step(1'b1, rfmt(11'h558, 5'd7, 5'd31, 5'd6), 1'b0, 1'b0);
      idle();
   endtask

   task automatic test_flag_stall();
      step(1'b1, rfmt(11'h758, 5'd3, 5'd2, 5'd1), 1'b0, 1'b0);
      step(1'b1, 32'h54000040, 1'b0, 1'b1);
      total++;
      if (id_bcond !== 1'b1) begin
         bad++;
         $display("FAIL bcond_decode got=%b want=1", id_bcond);
      end
      step(1'b1, 32'h54000040, 1'b0, 1'b0);
      step(1'b1, {10'b1001000100, 12'h004, 5'd2, 5'd3}, 1'b0, 1'b0);
      step(1'b1, 32'h54000040, 1'b0, 1'b0);
      idle();
   endtask

   task automatic test_source_select();
      // ADDI: bits [20:16] hold 5 but Rm is not read
      step(1'b1, dfmt(11'h7C2, 5'd2, 5'd5), 1'b0, 1'b0);
      step(1'b1, {10'b1001000100, 12'h140, 5'd9, 5'd8}, 1'b0, 1'b0);
      // B: bits [9:5] hold 5 but Rn is not read
      step(1'b1, dfmt(11'h7C2, 5'd2, 5'd5), 1'b0, 1'b0);
      step(1'b1, 32'h140000A0, 1'b0, 1'b0);
      total++;
      if (id_uncond_br !== 1'b1) begin
         bad++;
         $display("FAIL b_decode got=%b want=1", id_uncond_br);
      end
      // STUR reads Rt through instr[4:0]
      step(1'b1, dfmt(11'h7C2, 5'd2, 5'd5), 1'b0, 1'b0);
      step(1'b1, dfmt(11'h7C0, 5'd9, 5'd5), 1'b0, 1'b1);
      step(1'b1, dfmt(11'h7C0, 5'd9, 5'd5), 1'b0, 1'b0);
      // CBZ reads Rt through instr[4:0]
      step(1'b1, dfmt(11'h7C2, 5'd2, 5'd5), 1'b0, 1'b0);
      step(1'b1, 32'hB4000045, 1'b0, 1'b1);
      total++;
      if ({id_cbz, id_reg2loc} !== 2'b10) begin
         bad++;
         $display("FAIL cbz_decode got cbz=%b r2l=%b want 1/0", id_cbz, id_reg2loc);
      end
      step(1'b1, 32'hB4000045, 1'b0, 1'b0);
      step(1'b1, 32'hD61F0040, 1'b0, 1'b0);
      total++;
      if (id_br !== 1'b1) begin
         bad++;
         $display("FAIL br_decode got=%b want=1", id_br);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      step(1'b1, dfmt(11'h7C2, 5'd2, 5'd5), 1'b0, 1'b0);
      step(1'b1, rfmt(11'h558, 5'd7, 5'd5, 5'd6), 1'b0, 1'b1);
      step(1'b1, rfmt(11'h558, 5'd7, 5'd5, 5'd6), 1'b0, 1'b0);
      step(1'b1, dfmt(11'h7C2, 5'd6, 5'd7), 1'b0, 1'b0);
      step(1'b1, rfmt(11'h558, 5'd7, 5'd1, 5'd8), 1'b0, 1'b1);
      step(1'b1, rfmt(11'h558, 5'd7, 5'd1, 5'd8), 1'b0, 1'b0);
      step(1'b1, dfmt(11'h7C2, 5'd2, 5'd10), 1'b0, 1'b0);
      step(1'b1, dfmt(11'h7C2, 5'd10, 5'd11), 1'b0, 1'b1);
      step(1'b1, dfmt(11'h7C2, 5'd10, 5'd11), 1'b0, 1'b0);
      idle();
   endtask

   task automatic test_flush();
      int stalls_before;
      step(1'b1, dfmt(11'h7C2, 5'd2, 5'd5), 1'b0, 1'b0);
      stalls_before = exp_stalls;
      step(1'b1, rfmt(11'h558, 5'd7, 5'd5, 5'd6), 1'b1, 1'b0);
      total++;
      if ({flush_count, stall_count} !== {16'(exp_flushes), 16'(stalls_before)}) begin
         bad++;
         $display("FAIL flush_counts got f=%0d s=%0d want f=%0d s=%0d",
                  flush_count, stall_count, exp_flushes, stalls_before);
      end
      idle();
   endtask

   task automatic test_illegal();
      step(1'b1, 32'h00000000, 1'b0, 1'b0);
      total++;
      if (ex_rd !== 5'd31) begin
         bad++;
         $display("FAIL illegal_bubble got ex_rd=%0d want=31", ex_rd);
      end
      idle();
   endtask

   task automatic test_bl();
      step(1'b1, 32'h94000010, 1'b0, 1'b0);
      idle();
      idle();
      total++;
      if ({wb_rd, wb_reg_wri, wb_write_rd} !== {5'd30, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL bl_wb got rd=%0d regwri=%b wrd=%b want 30/1/0", wb_rd, wb_reg_wri, wb_write_rd);
      end
      idle();
   endtask

   task automatic test_saturation();
      logic [1:0] want_s, want_f;
      want_s = (exp_stalls > 3) ? 2'd3 : 2'(exp_stalls);
      want_f = (exp_flushes > 3) ? 2'd3 : 2'(exp_flushes);
      total++;
      if (stall_count !== 16'(exp_stalls)) begin
         bad++;
         $display("FAIL stall_total got=%0d want=%0d", stall_count, exp_stalls);
      end
      total++;
      if ({s_stall_count, s_flush_count} !== {want_s, want_f}) begin
         bad++;
         $display("FAIL counter_saturate got s=%0d f=%0d want s=%0d f=%0d",
                  s_stall_count, s_flush_count, want_s, want_f);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      id_valid = 1'b0;
      id_instr = '0;
      flush_i  = 1'b0;
      test_reset();
      test_adds();
      test_mid_stall_reset();
      test_load_use();
      test_x31_no_stall();
      test_flag_stall();
      test_source_select();
      test_back_to_back();
      test_flush();
      test_illegal();
      test_bl();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
